// File: rtl/pong_pkg.sv
// Shared geometry defaults, FSM encoding, colours and small helpers for the Pong engine.
package pong_pkg;

    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_BALL_SPEED   = 2;
    localparam int DEF_PADDLE_STEP  = 8;
    localparam int DEF_SCORE_MAX    = 9;
    localparam int DEF_POINT_FRAMES = 60;
    localparam int DEF_NUM_PLAYERS  = 2;

    // Both paddles sit this far in from their screen edge.
    localparam int PADDLE_MARGIN = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_BALL  = 12'hFFF;
    localparam logic [11:0] COL_LEFT  = 12'h0F0;
    localparam logic [11:0] COL_RIGHT = 12'hF00;
    localparam logic [11:0] COL_NET   = 12'h888;

    typedef logic signed [10:0] coord_t;

    typedef struct packed {
        state_t state;
        coord_t ball_x;
        coord_t ball_y;
        logic   dir_x;
        logic   dir_y;
        coord_t paddle_l;
        coord_t paddle_r;
    } debug_t;

    function automatic logic overlap(input coord_t ball_y, input coord_t paddle_y,
                                     input coord_t ball_size, input coord_t paddle_h);
        return (ball_y + ball_size > paddle_y) && (ball_y < paddle_y + paddle_h);
    endfunction

    function automatic coord_t paddle_move(input coord_t y, input logic inc, input logic dec,
                                           input coord_t step, input coord_t max_y);
        coord_t r;
        r = y;
        if (dec) r = (y - step < 0) ? coord_t'(0) : y - step;
        else if (inc) r = (y + step > max_y) ? max_y : y + step;
        return r;
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Rotary encoder front end: synchronises A/B and emits one pulse per rising edge of A.
module quad_decoder (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec
);

    logic [1:0] a_sync;
    logic [1:0] b_sync;
    logic       a_prev;
    logic       rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
            a_prev <= 1'b0;
        end else begin
            a_sync <= {a_sync[0], a};
            b_sync <= {b_sync[0], b};
            a_prev <= a_sync[1];
        end
    end

    // B level at the A edge gives the turning direction.
    assign rise = a_sync[1] & ~a_prev;
    assign inc  = rise & b_sync[1];
    assign dec  = rise & ~b_sync[1];

endmodule

// File: rtl/pong_game_core.sv
// Pong engine: encoder-driven paddles, per-frame ball and scoring FSM, registered pixel colour.
module pong_game_core
    import pong_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
    parameter int SCORE_MAX    = DEF_SCORE_MAX,
    parameter int POINT_FRAMES = DEF_POINT_FRAMES,
    parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS
) (
    input  logic                   clk25,
    input  logic                   Reset,
    input  logic [NUM_PLAYERS-1:0] rota,
    input  logic [NUM_PLAYERS-1:0] rotb,
    input  logic                   serve,
    input  logic [9:0]             xpos,
    input  logic [9:0]             ypos,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue,
    output logic [3:0]             score_l,
    output logic [3:0]             score_r,
    output logic                   game_over,
    output debug_t                 debug
);

    localparam coord_t BS        = coord_t'(BALL_SIZE);
    localparam coord_t SPEED     = coord_t'(BALL_SPEED);
    localparam coord_t PH        = coord_t'(PADDLE_H);
    localparam coord_t PW        = coord_t'(PADDLE_W);
    localparam coord_t STEP      = coord_t'(PADDLE_STEP);
    localparam coord_t HACT      = coord_t'(H_ACTIVE);
    localparam coord_t VACT      = coord_t'(V_ACTIVE);
    localparam coord_t PLX       = coord_t'(PADDLE_MARGIN);
    localparam coord_t PRX       = coord_t'(H_ACTIVE - PADDLE_MARGIN - PADDLE_W);
    localparam coord_t X_HIT_L   = coord_t'(PADDLE_MARGIN + PADDLE_W);
    localparam coord_t X_HIT_R   = coord_t'(H_ACTIVE - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);
    localparam coord_t X_MAX     = coord_t'(H_ACTIVE - BALL_SIZE);
    localparam coord_t Y_MAX     = coord_t'(V_ACTIVE - BALL_SIZE);
    localparam coord_t P_MAX     = coord_t'(V_ACTIVE - PADDLE_H);
    localparam coord_t BALL_X0   = coord_t'((H_ACTIVE - BALL_SIZE) / 2);
    localparam coord_t BALL_Y0   = coord_t'((V_ACTIVE - BALL_SIZE) / 2);
    localparam coord_t PADDLE_Y0 = coord_t'((V_ACTIVE - PADDLE_H) / 2);
    localparam coord_t NET_X0    = coord_t'(H_ACTIVE / 2 - 1);
    localparam coord_t NET_X1    = coord_t'(H_ACTIVE / 2);
    localparam logic [3:0] SMAX  = 4'(SCORE_MAX);
    // Loaded one short so the freeze spans exactly POINT_FRAMES ticks.
    localparam logic [7:0] HOLD  = 8'(POINT_FRAMES - 1);

    state_t      state, state_next;
    coord_t      ball_x, ball_y, bx_next, by_next;
    logic        dir_x, dir_y, dx_next, dy_next;
    logic        serve_dir, serve_dir_next;
    logic [3:0]  sl_next, sr_next;
    logic [7:0]  point_cnt, cnt_next;
    coord_t      paddle_l, paddle_r;
    coord_t      step_x, step_y, nx, ny;
    logic        ndx, ndy;
    logic        inc_l, dec_l, inc_r, dec_r;
    logic        frame_tick;
    coord_t      px, py;
    logic [11:0] rgb, rgb_next;

    quad_decoder u_dec_l (.clk(clk25), .reset(Reset), .a(rota[0]), .b(rotb[0]), .inc(inc_l), .dec(dec_l));

    generate
        if (NUM_PLAYERS > 1) begin : g_right
            quad_decoder u_dec_r (.clk(clk25), .reset(Reset), .a(rota[1]), .b(rotb[1]), .inc(inc_r), .dec(dec_r));
        end else begin : g_wall
            assign inc_r = 1'b0;
            assign dec_r = 1'b0;
        end
    endgenerate

    assign frame_tick = (xpos == 10'd0) && (ypos == 10'(V_ACTIVE));

    always_ff @(posedge clk25) begin
        if (Reset) begin
            state     <= ST_IDLE;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            serve_dir <= 1'b1;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            point_cnt <= 8'd0;
            paddle_l  <= PADDLE_Y0;
            paddle_r  <= PADDLE_Y0;
            rgb       <= COL_BLACK;
        end else begin
            state     <= state_next;
            ball_x    <= bx_next;
            ball_y    <= by_next;
            dir_x     <= dx_next;
            dir_y     <= dy_next;
            serve_dir <= serve_dir_next;
            score_l   <= sl_next;
            score_r   <= sr_next;
            point_cnt <= cnt_next;
            paddle_l  <= paddle_move(paddle_l, inc_l, dec_l, STEP, P_MAX);
            paddle_r  <= paddle_move(paddle_r, inc_r, dec_r, STEP, P_MAX);
            rgb       <= rgb_next;
        end
    end

    // dir_x/dir_y: 1 = moving towards +x/+y.
    always_comb begin
        state_next     = state;
        bx_next        = ball_x;
        by_next        = ball_y;
        dx_next        = dir_x;
        dy_next        = dir_y;
        serve_dir_next = serve_dir;
        sl_next        = score_l;
        sr_next        = score_r;
        cnt_next       = point_cnt;
        step_x         = dir_x ? ball_x + SPEED : ball_x - SPEED;
        step_y         = dir_y ? ball_y + SPEED : ball_y - SPEED;
        ny             = step_y;
        ndy            = dir_y;
        nx             = step_x;
        ndx            = dir_x;

        if (step_y <= 0) begin
            ny  = 0;
            ndy = 1'b1;
        end else if (step_y >= Y_MAX) begin
            ny  = Y_MAX;
            ndy = 1'b0;
        end
        if (!dir_x && step_x <= X_HIT_L && overlap(ny, paddle_l, BS, PH)) begin
            nx  = X_HIT_L;
            ndx = 1'b1;
        end else if (dir_x && step_x >= X_HIT_R && (NUM_PLAYERS == 1 || overlap(ny, paddle_r, BS, PH))) begin
            nx  = X_HIT_R;
            ndx = 1'b0;
        end

        if (frame_tick) begin
            case (state)
                ST_IDLE: if (serve) state_next = ST_PLAY;
                ST_PLAY: begin
                    if (nx <= 0) begin
                        state_next     = ST_POINT;
                        sr_next        = (score_r == SMAX) ? score_r : score_r + 4'd1;
                        cnt_next       = HOLD;
                        serve_dir_next = 1'b0;
                    end else if (nx >= X_MAX) begin
                        state_next     = ST_POINT;
                        sl_next        = (score_l == SMAX) ? score_l : score_l + 4'd1;
                        cnt_next       = HOLD;
                        serve_dir_next = 1'b1;
                    end else begin
                        bx_next = nx;
                        by_next = ny;
                        dx_next = ndx;
                        dy_next = ndy;
                    end
                end
                ST_POINT: begin
                    if (point_cnt == 8'd0) begin
                        state_next = (score_l == SMAX || score_r == SMAX) ? ST_OVER : ST_PLAY;
                        bx_next    = BALL_X0;
                        by_next    = BALL_Y0;
                        dx_next    = serve_dir;
                    end else begin
                        cnt_next = point_cnt - 8'd1;
                    end
                end
                ST_OVER: begin
                    if (serve) begin
                        state_next = ST_IDLE;
                        sl_next    = 4'd0;
                        sr_next    = 4'd0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        px       = $signed({1'b0, xpos});
        py       = $signed({1'b0, ypos});
        rgb_next = COL_BLACK;
        if (px >= HACT || py >= VACT)
            rgb_next = COL_BLACK;
        else if (px >= ball_x && px < ball_x + BS && py >= ball_y && py < ball_y + BS)
            rgb_next = COL_BALL;
        else if (px >= PLX && px < PLX + PW && py >= paddle_l && py < paddle_l + PH)
            rgb_next = COL_LEFT;
        else if (px >= PRX && px < PRX + PW &&
                 (NUM_PLAYERS == 1 || (py >= paddle_r && py < paddle_r + PH)))
            rgb_next = COL_RIGHT;
        else if ((px == NET_X0 || px == NET_X1) && !ypos[4])
            rgb_next = COL_NET;
    end

    assign red       = rgb[11:8];
    assign green     = rgb[7:4];
    assign blue      = rgb[3:0];
    assign game_over = (state == ST_OVER);

    assign debug.state    = state;
    assign debug.ball_x   = ball_x;
    assign debug.ball_y   = ball_y;
    assign debug.dir_x    = dir_x;
    assign debug.dir_y    = dir_y;
    assign debug.paddle_l = paddle_l;
    assign debug.paddle_r = paddle_r;

endmodule
